// File: rtl/mastermind_solver.sv
// Mastermind code breaker: searches for the first candidate consistent with all feedback.
// Optional search-cycle counter under `MASTERMIND_SOLVER_CYCLE_COUNT_EN`.
module mastermind_solver #(
  parameter int MAX_GUESSES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [11:0] guess,
  output logic        guess_valid,
  input  logic        guess_ready,
  input  logic        fb_valid,
  input  logic [2:0]  red,
  input  logic [2:0]  white,
  output logic [3:0]  guess_count,
  output logic        busy,
  output logic        solved,
  output logic        fail
`ifdef MASTERMIND_SOLVER_CYCLE_COUNT_EN
  ,
  output logic [15:0] search_cycles
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT_FB,
    DONE,
    FAIL
  } state_t;

  state_t      state;
  logic [11:0] cand;
  logic [3:0]  k;
  logic [3:0]  n_hist;

  logic [11:0] hist_g [MAX_GUESSES];
  logic [2:0]  hist_r [MAX_GUESSES];
  logic [2:0]  hist_w [MAX_GUESSES];

  logic [3:0]  k_rd;
  logic [2:0]  sc_r;
  logic [2:0]  sc_w;
  logic        hist_match;
  logic        bad_fb;
  logic        start_ok;

  function automatic logic [5:0] score(
    input logic [11:0] a,
    input logic [11:0] b
  );
    logic [2:0] r;
    logic [2:0] m;
    logic [2:0] ca;
    logic [2:0] cb;
    r = 3'd0;
    m = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (a[3*i +: 3] == b[3*i +: 3]) r = r + 3'd1;
    end
    for (int c = 0; c < 8; c++) begin
      ca = 3'd0;
      cb = 3'd0;
      for (int i = 0; i < 4; i++) begin
        if (a[3*i +: 3] == 3'(c)) ca = ca + 3'd1;
        if (b[3*i +: 3] == 3'(c)) cb = cb + 3'd1;
      end
      m = m + ((ca < cb) ? ca : cb);
    end
    return {r, m - r};
  endfunction

  // k reaches n_hist only on the pass cycle; keep the read in range
  assign k_rd = (k < 4'(MAX_GUESSES)) ? k : 4'd0;
  assign {sc_r, sc_w} = score(cand, hist_g[k_rd]);
  assign hist_match = (sc_r == hist_r[k_rd]) &&
                      (sc_w == hist_w[k_rd]);

  assign bad_fb = (({1'b0, red} + {1'b0, white}) > 4'd4) ||
                  ((red == 3'd3) && (white == 3'd1));

  assign start_ok = start &&
                    ((state == IDLE) ||
                     (state == DONE) ||
                     (state == FAIL));

  assign busy   = (state == CHECK) ||
                  (state == ISSUE) ||
                  (state == WAIT_FB);
  assign solved = (state == DONE);
  assign fail   = (state == FAIL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= 12'd0;
      k           <= 4'd0;
      n_hist      <= 4'd0;
      guess       <= 12'd0;
      guess_valid <= 1'b0;
      guess_count <= 4'd0;
      for (int i = 0; i < MAX_GUESSES; i++) begin
        hist_g[i] <= 12'd0;
        hist_r[i] <= 3'd0;
        hist_w[i] <= 3'd0;
      end
    end else begin
      unique case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state       <= CHECK;
            cand        <= 12'd0;
            k           <= 4'd0;
            n_hist      <= 4'd0;
            guess_count <= 4'd0;
            for (int i = 0; i < MAX_GUESSES; i++) begin
              hist_g[i] <= 12'd0;
              hist_r[i] <= 3'd0;
              hist_w[i] <= 3'd0;
            end
          end
        end
        CHECK: begin
          if (k == n_hist) begin
            state       <= ISSUE;
            guess       <= cand;
            guess_valid <= 1'b1;
          end else if (hist_match) begin
            k <= k + 4'd1;
          end else if (cand == 12'hFFF) begin
            state <= FAIL;
          end else begin
            cand <= cand + 12'd1;
            k    <= 4'd0;
          end
        end
        ISSUE: begin
          if (guess_ready) begin
            state       <= WAIT_FB;
            guess_valid <= 1'b0;
            guess_count <= guess_count + 4'd1;
          end
        end
        WAIT_FB: begin
          if (fb_valid) begin
            hist_g[n_hist] <= cand;
            hist_r[n_hist] <= red;
            hist_w[n_hist] <= white;
            n_hist         <= n_hist + 4'd1;
            if (bad_fb) begin
              state <= FAIL;
            end else if (red == 3'd4) begin
              state <= DONE;
            end else if (guess_count == 4'(MAX_GUESSES)) begin
              state <= FAIL;
            end else begin
              state <= CHECK;
              cand  <= cand + 12'd1;
              k     <= 4'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MASTERMIND_SOLVER_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      search_cycles <= 16'd0;
    end else if ((state == CHECK) && (search_cycles != 16'hFFFF)) begin
      search_cycles <= search_cycles + 16'd1;
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_mastermind_solver.sv
// Bench for mastermind_solver: directed corner cases plus closed-loop games
// scored by a reference model, checked through a guess/outcome scoreboard.
module tb_mastermind_solver;

  localparam int MAXG = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] guess;
  logic        guess_valid;
  logic        guess_ready;
  logic        fb_valid;
  logic [2:0]  red;
  logic [2:0]  white;
  logic [3:0]  guess_count;
  logic        busy;
  logic        solved;
  logic        fail;
`ifdef MASTERMIND_SOLVER_CYCLE_COUNT_EN
  logic [15:0] search_cycles;
`endif

  mastermind_solver #(.MAX_GUESSES(MAXG)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .guess_ready (guess_ready),
    .fb_valid    (fb_valid),
    .red         (red),
    .white       (white),
    .guess_count (guess_count),
    .busy        (busy),
    .solved      (solved),
    .fail        (fail)
`ifdef MASTERMIND_SOLVER_CYCLE_COUNT_EN
    ,
    .search_cycles (search_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       f;
    logic [3:0] n;
  } outc_t;

  int    n_tests = 0;
  int    n_bad   = 0;
  int    exp_q[$];
  outc_t out_q[$];
  int    h_g[$];
  int    h_r[$];
  int    h_w[$];
  logic  sb_en = 1'b0;
  logic  ended = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference scorer: digits and colour histograms, straight from the game rules
  function automatic void ref_score(input int a, input int b,
                                    output int r, output int w);
    int ca[8];
    int cb[8];
    int tot;
    r = 0;
    tot = 0;
    for (int c = 0; c < 8; c++) begin
      ca[c] = 0;
      cb[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      int da;
      int db;
      da = (a >> (3 * i)) & 7;
      db = (b >> (3 * i)) & 7;
      if (da == db) r++;
      ca[da]++;
      cb[db]++;
    end
    for (int c = 0; c < 8; c++) tot += (ca[c] < cb[c]) ? ca[c] : cb[c];
    w = tot - r;
  endfunction

  function automatic bit consistent(input int x);
    int r;
    int w;
    for (int j = 0; j < h_g.size(); j++) begin
      ref_score(x, h_g[j], r, w);
      if (r != h_r[j] || w != h_w[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Expected game: always guess the smallest untried code consistent so far
  function automatic void model_game(input int secret);
    int    c;
    int    cnt;
    int    found;
    int    r;
    int    w;
    outc_t o;
    h_g.delete();
    h_r.delete();
    h_w.delete();
    c = 0;
    cnt = 0;
    while (1) begin
      found = -1;
      for (int x = c; x < 4096; x++) begin
        if (consistent(x)) begin
          found = x;
          break;
        end
      end
      if (found < 0) begin
        o = '{1'b0, 1'b1, 4'(cnt)};
        out_q.push_back(o);
        return;
      end
      exp_q.push_back(found);
      cnt++;
      ref_score(found, secret, r, w);
      if (r == 4) begin
        o = '{1'b1, 1'b0, 4'(cnt)};
        out_q.push_back(o);
        return;
      end
      if (cnt == MAXG) begin
        o = '{1'b0, 1'b1, 4'(cnt)};
        out_q.push_back(o);
        return;
      end
      h_g.push_back(found);
      h_r.push_back(r);
      h_w.push_back(w);
      c = found + 1;
    end
  endfunction

  // Scoreboard monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (sb_en) begin
      if (guess_valid && guess_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_guess", {20'd0, guess}, 32'hFFFFFFFF);
        end else begin
          check("guess_seq", {20'd0, guess}, exp_q.pop_front());
        end
      end
      if ((solved || fail) && !ended) begin
        ended = 1'b1;
        if (out_q.size() == 0) begin
          check("unexpected_end", 32'd1, 32'd0);
        end else begin
          outc_t o;
          o = out_q.pop_front();
          check("outcome", {26'd0, solved, fail, guess_count},
                {26'd0, o.s, o.f, o.n});
          if (fail) check("fail_at_max", {28'd0, guess_count}, MAXG);
        end
      end
      if (!(solved || fail)) ended = 1'b0;
    end
  end

  task automatic wait_valid(input string name);
    int budget;
    budget = 10000;
    while (!guess_valid && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check(name, 32'd0, 32'd1);
  endtask

  task automatic play(input logic [11:0] secret);
    int budget;
    int r;
    int w;
    model_game(int'(secret));
    start = 1'b1;
    tick();
    start = 1'b0;
    budget = 20000;
    while (!(solved || fail) && budget > 0) begin
      if (guess_valid) begin
        repeat ($urandom_range(2)) tick();
        guess_ready = 1'b1;
        tick();
        guess_ready = 1'b0;
        repeat ($urandom_range(2)) tick();
        ref_score(int'(guess), int'(secret), r, w);
        red = 3'(r);
        white = 3'(w);
        fb_valid = 1'b1;
        tick();
        fb_valid = 1'b0;
      end else begin
        tick();
      end
      budget--;
    end
    if (budget == 0) check("game_timeout", {20'd0, secret}, 32'hFFFFFFFF);
    tick();
    check("guesses_drained", exp_q.size(), 0);
    exp_q.delete();
    out_q.delete();
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, guess, guess_valid, guess_count, busy, solved, fail};
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    guess_ready = 1'b0;
    fb_valid = 1'b0;
    red = 3'd0;
    white = 3'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_state", outs(), 32'd0);

    // First guess latency and an immediate win
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_not_valid", {30'd0, guess_valid, busy}, 32'b01);
    tick();
    check("t2_first_guess", {19'd0, guess_valid, guess}, {19'd0, 1'b1, 12'h000});
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("accept_count", {27'd0, guess_valid, guess_count}, {27'd0, 1'b0, 4'd1});
    red = 3'd4;
    white = 3'd0;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    check("win_outputs", outs(), {12'd0, 12'h000, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0});

    // Stalled handshake, then all-miss feedback
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {15'd0, guess_valid, guess, guess_count},
            {15'd0, 1'b1, 12'h000, 4'd0});
      tick();
    end
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("stall_accept", {28'd0, guess_count}, 32'd1);
    red = 3'd0;
    white = 3'd0;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    wait_valid("wait_second");
    check("second_guess", {20'd0, guess}, 32'h249);

    // Impossible feedback ends the game, restart clears it
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    red = 3'd3;
    white = 3'd2;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    check("bad_fb_fail", outs(), {12'd0, 12'h249, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart", {15'd0, guess_valid, guess, guess_count},
          {15'd0, 1'b1, 12'h000, 4'd0});

    // Reset while searching
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    red = 3'd0;
    white = 3'd0;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    check("in_check", {30'd0, busy, guess_valid}, 32'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_in_check", outs(), 32'd0);
    red = 3'd4;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    check("fb_ignored_idle", outs(), 32'd0);

    // Reset while waiting for feedback
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    guess_ready = 1'b1;
    tick();
    guess_ready = 1'b0;
    check("in_wait_fb", {30'd0, busy, guess_valid}, 32'b10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_in_wait", outs(), 32'd0);
    red = 3'd4;
    fb_valid = 1'b1;
    tick();
    fb_valid = 1'b0;
    check("fb_ignored_after", outs(), 32'd0);

    // Closed-loop games against the reference scorer
    sb_en = 1'b1;
    play(12'h000);
    play(12'hFFF);
    play(12'h2CF);
    for (int g = 0; g < 64; g++) play(12'($urandom_range(1023)));
    sb_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_bad);
    $finish;
  end

endmodule
